// File: rtl/calc1_port_driver.sv
// calc1_port_driver: buffers arithmetic transactions and issues them one at a time
// to a calc1 port (command/op1, then op2), then captures the response or a timeout.
module calc1_port_driver #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic        txn_valid,
    output logic        txn_ready,
    input  logic [3:0]  txn_cmd,
    input  logic [31:0] txn_op1,
    input  logic [31:0] txn_op2,
    output logic [3:0]  req_cmd_out,
    output logic [31:0] req_data_out,
    input  logic [1:0]  out_resp,
    input  logic [31:0] out_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [1:0]  rsp_code,
    output logic [31:0] rsp_data,
    output logic [3:0]  rsp_cmd,
    output logic        rsp_timeout,
    output logic        busy
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    // state   | meaning
    // S_IDLE  | bus quiet; pop next entry once the previous result was accepted
    // S_SEND1 | drive command and op1 on the next edge
    // S_SEND2 | drive op2 (command field zero) on the next edge
    // S_WAIT  | wait for a non-zero response or timeout
    // S_HOLD  | result presented downstream until rsp_ready
    typedef enum logic [2:0] {S_IDLE, S_SEND1, S_SEND2, S_WAIT, S_HOLD} state_t;

    state_t      state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full_q, full_d;
    logic [3:0]    cur_cmd_q, cur_cmd_d;
    logic [31:0]   cur_op1_q, cur_op1_d, cur_op2_q, cur_op2_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [3:0]    req_cmd_q, req_cmd_d;
    logic [31:0]   req_data_q, req_data_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [1:0]    rsp_code_q, rsp_code_d;
    logic [31:0]   rsp_data_q, rsp_data_d;
    logic [3:0]    rsp_cmd_q, rsp_cmd_d;
    logic          rsp_timeout_q, rsp_timeout_d;
    logic          spurious_q, spurious_d;
    logic          push, pop;

    logic [3:0]  mem_cmd [FIFO_DEPTH];
    logic [31:0] mem_op1 [FIFO_DEPTH];
    logic [31:0] mem_op2 [FIFO_DEPTH];

    always_ff @(posedge c_clk) begin
        if (push) begin
            mem_cmd[wr_ptr_q] <= txn_cmd;
            mem_op1[wr_ptr_q] <= txn_op1;
            mem_op2[wr_ptr_q] <= txn_op2;
        end
    end

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        cur_cmd_d     = cur_cmd_q;
        cur_op1_d     = cur_op1_q;
        cur_op2_d     = cur_op2_q;
        tmo_d         = tmo_q;
        req_cmd_d     = '0;
        req_data_d    = '0;
        rsp_valid_d   = rsp_valid_q;
        rsp_code_d    = rsp_code_q;
        rsp_data_d    = rsp_data_q;
        rsp_cmd_d     = rsp_cmd_q;
        rsp_timeout_d = rsp_timeout_q;
        spurious_d    = spurious_q;
        push          = txn_valid && !full_q;
        pop           = 1'b0;

        if ((out_resp != 2'd0) && (state_q != S_WAIT)) begin
            spurious_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if ((count_q != '0) && !rsp_valid_q) begin
                    pop       = 1'b1;
                    cur_cmd_d = mem_cmd[rd_ptr_q];
                    cur_op1_d = mem_op1[rd_ptr_q];
                    cur_op2_d = mem_op2[rd_ptr_q];
                    state_d   = S_SEND1;
                end
            end
            S_SEND1: begin
                req_cmd_d  = cur_cmd_q;
                req_data_d = cur_op1_q;
                state_d    = S_SEND2;
            end
            S_SEND2: begin
                req_data_d = cur_op2_q;
                tmo_d      = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                // a response on the terminal cycle takes priority over the timeout
                if (out_resp != 2'd0) begin
                    rsp_valid_d   = 1'b1;
                    rsp_code_d    = out_resp;
                    rsp_data_d    = out_data;
                    rsp_cmd_d     = cur_cmd_q;
                    rsp_timeout_d = 1'b0;
                    state_d       = S_HOLD;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    rsp_valid_d   = 1'b1;
                    rsp_code_d    = 2'd0;
                    rsp_data_d    = '0;
                    rsp_cmd_d     = cur_cmd_q;
                    rsp_timeout_d = 1'b1;
                    state_d       = S_HOLD;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_HOLD: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        full_d = (count_d == (AW+1)'(FIFO_DEPTH));
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            full_q        <= 1'b0;
            cur_cmd_q     <= '0;
            cur_op1_q     <= '0;
            cur_op2_q     <= '0;
            tmo_q         <= '0;
            req_cmd_q     <= '0;
            req_data_q    <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_code_q    <= '0;
            rsp_data_q    <= '0;
            rsp_cmd_q     <= '0;
            rsp_timeout_q <= 1'b0;
            spurious_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            full_q        <= full_d;
            cur_cmd_q     <= cur_cmd_d;
            cur_op1_q     <= cur_op1_d;
            cur_op2_q     <= cur_op2_d;
            tmo_q         <= tmo_d;
            req_cmd_q     <= req_cmd_d;
            req_data_q    <= req_data_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_code_q    <= rsp_code_d;
            rsp_data_q    <= rsp_data_d;
            rsp_cmd_q     <= rsp_cmd_d;
            rsp_timeout_q <= rsp_timeout_d;
            spurious_q    <= spurious_d;
        end
    end

    assign txn_ready    = !full_q;
    assign req_cmd_out  = req_cmd_q;
    assign req_data_out = req_data_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_code     = rsp_code_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_cmd      = rsp_cmd_q;
    assign rsp_timeout  = rsp_timeout_q;
    assign busy         = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_calc1_port_driver.sv
// Directed bench for calc1_port_driver with a small behavioural calc1 responder.
module tb_calc1_port_driver;
    logic        c_clk = 1'b0;
    logic        reset;
    logic        txn_valid;
    logic        txn_ready;
    logic [3:0]  txn_cmd;
    logic [31:0] txn_op1, txn_op2;
    logic [3:0]  req_cmd_out;
    logic [31:0] req_data_out;
    logic [1:0]  out_resp;
    logic [31:0] out_data;
    logic        rsp_valid, rsp_ready;
    logic [1:0]  rsp_code;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_cmd;
    logic        rsp_timeout, busy;

    logic [1:0]  model_resp;
    logic [1:0]  spur_resp;
    logic [31:0] model_data;
    assign out_resp = model_resp | spur_resp;
    assign out_data = model_data;

    int checks = 0;
    int errors = 0;
    int model_delay = 2;
    bit model_silent = 1'b0;
    logic [3:0]  issued_cmd [$];
    logic [31:0] issued_op1 [$];

    always #5 c_clk = ~c_clk;

    calc1_port_driver #(.FIFO_DEPTH(4), .TIMEOUT(64)) dut (
        .c_clk(c_clk), .reset(reset),
        .txn_valid(txn_valid), .txn_ready(txn_ready), .txn_cmd(txn_cmd),
        .txn_op1(txn_op1), .txn_op2(txn_op2),
        .req_cmd_out(req_cmd_out), .req_data_out(req_data_out),
        .out_resp(out_resp), .out_data(out_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_code(rsp_code),
        .rsp_data(rsp_data), .rsp_cmd(rsp_cmd), .rsp_timeout(rsp_timeout),
        .busy(busy)
    );

    // responder: latches command/op1, then op2, answers model_delay cycles later for one cycle
    initial begin : calc1_model
        logic [3:0]  c;
        logic [31:0] a, b, r;
        logic [1:0]  code;
        model_resp = 2'd0;
        model_data = 32'd0;
        forever begin
            @(posedge c_clk); #2;
            if (req_cmd_out != 4'd0) begin
                c = req_cmd_out;
                a = req_data_out;
                issued_cmd.push_back(c);
                issued_op1.push_back(a);
                @(posedge c_clk); #2;
                b = req_data_out;
                code = 2'd1;
                r = 32'd0;
                case (c)
                    4'd1: begin r = a + b; if (r < a) begin code = 2'd2; r = 32'd0; end end
                    4'd2: begin if (a < b) code = 2'd2; else r = a - b; end
                    4'd5: r = a << b[4:0];
                    4'd6: r = a >> b[4:0];
                    default: code = 2'd2;
                endcase
                if (!model_silent) begin
                    repeat (model_delay) @(posedge c_clk);
                    #2;
                    model_resp = code;
                    model_data = r;
                    @(posedge c_clk); #2;
                    model_resp = 2'd0;
                    model_data = 32'd0;
                end
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_txn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        bit done = 1'b0;
        txn_valid = 1'b1; txn_cmd = c; txn_op1 = a; txn_op2 = b;
        for (int i = 0; i < 200 && !done; i++) begin
            done = txn_ready;
            @(posedge c_clk); #1;
        end
        txn_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL push_accept: txn_ready never high, got 0 expected 1");
        end
    endtask

    task automatic wait_rsp(input int budget, output int cycles, output bit ok);
        cycles = 0;
        while (!rsp_valid && cycles < budget) begin
            @(posedge c_clk); #1;
            cycles++;
        end
        ok = rsp_valid;
    endtask

    task automatic test_reset_and_add();
        int cyc; bit ok;
        reset = 1'b1; txn_valid = 1'b0; txn_cmd = 4'd0; txn_op1 = 32'd0; txn_op2 = 32'd0;
        rsp_ready = 1'b0; spur_resp = 2'd0;
        #1 reset = 1'b0;
        #2;
        checks++;
        if (txn_ready !== 1'b1 || rsp_valid !== 1'b0 || req_cmd_out !== 4'd0 || req_data_out !== 32'd0 ||
            rsp_code !== 2'd0 || rsp_data !== 32'd0 || rsp_cmd !== 4'd0 || rsp_timeout !== 1'b0 ||
            busy !== 1'b0 || dut.spurious_q !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: got ready=%b vld=%b cmd=%h data=%h code=%h rdata=%h rcmd=%h tmo=%b busy=%b expected 1 0 0 0 0 0 0 0 0",
                     txn_ready, rsp_valid, req_cmd_out, req_data_out, rsp_code, rsp_data, rsp_cmd, rsp_timeout, busy);
        end
        txn_valid = 1'b1; txn_cmd = 4'd1; txn_op1 = 32'd5; txn_op2 = 32'd3;
        @(posedge c_clk); #1;
        checks++;
        if (busy !== 1'b0 || txn_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_no_push: got busy=%b ready=%b expected 0 1", busy, txn_ready);
        end
        @(negedge c_clk) reset = 1'b1;
        @(posedge c_clk); #1;
        txn_valid = 1'b0;
        checks++;
        if (req_cmd_out !== 4'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL latency_edge1: got cmd=%h busy=%b expected 0 1", req_cmd_out, busy);
        end
        @(posedge c_clk); #1;
        checks++;
        if (req_cmd_out !== 4'd0) begin
            errors++;
            $display("FAIL latency_edge2: got cmd=%h expected 0", req_cmd_out);
        end
        @(posedge c_clk); #1;
        checks++;
        if (req_cmd_out !== 4'd1 || req_data_out !== 32'd5) begin
            errors++;
            $display("FAIL send1: got cmd=%h data=%h expected 1 00000005", req_cmd_out, req_data_out);
        end
        @(posedge c_clk); #1;
        checks++;
        if (req_cmd_out !== 4'd0 || req_data_out !== 32'd3) begin
            errors++;
            $display("FAIL send2: got cmd=%h data=%h expected 0 00000003", req_cmd_out, req_data_out);
        end
        wait_rsp(40, cyc, ok);
        checks++;
        if (!ok || cyc != 3) begin
            errors++;
            $display("FAIL add_latency: got valid=%b after %0d cycles expected 1 after 3", ok, cyc);
        end
        checks++;
        if (rsp_code !== 2'd1 || rsp_data !== 32'd8 || rsp_cmd !== 4'd1 || rsp_timeout !== 1'b0) begin
            errors++;
            $display("FAIL add_result: got code=%h data=%h cmd=%h tmo=%b expected 1 00000008 1 0",
                     rsp_code, rsp_data, rsp_cmd, rsp_timeout);
        end
    endtask

    // enters with the add result still held (rsp_ready low)
    task automatic test_back_to_back();
        logic [3:0]  exp_cmd  [5] = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd2};
        logic [31:0] exp_op1  [5] = '{32'd10, 32'd50, 32'd1, 32'd256, 32'd100};
        logic [31:0] exp_data [5] = '{32'd30, 32'd42, 32'd16, 32'd16, 32'd99};
        int cyc; bit ok; bit bad;
        issued_cmd.delete(); issued_op1.delete();
        push_txn(4'd1, 32'd10, 32'd20);
        push_txn(4'd2, 32'd50, 32'd8);
        push_txn(4'd5, 32'd1, 32'd4);
        push_txn(4'd6, 32'd256, 32'd4);
        checks++;
        if (txn_ready !== 1'b0 || dut.count_q !== 3'd4) begin
            errors++;
            $display("FAIL full_ready: got ready=%b count=%0d expected 0 4", txn_ready, dut.count_q);
        end
        txn_valid = 1'b1; txn_cmd = 4'd2; txn_op1 = 32'd100; txn_op2 = 32'd1;
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge c_clk); #1;
            if (txn_ready !== 1'b0 || rsp_valid !== 1'b1 || req_cmd_out !== 4'd0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL full_blocked: ready/valid/cmd changed while full, got ready=%b vld=%b expected 0 1", txn_ready, rsp_valid);
        end
        rsp_ready = 1'b1;
        push_txn(4'd2, 32'd100, 32'd1);
        for (int i = 0; i < 5; i++) begin
            wait_rsp(40, cyc, ok);
            checks++;
            if (!ok || rsp_cmd !== exp_cmd[i] || rsp_code !== 2'd1 || rsp_data !== exp_data[i] || rsp_timeout !== 1'b0) begin
                errors++;
                $display("FAIL b2b_rsp%0d: got valid=%b cmd=%h code=%h data=%h expected 1 %h 1 %h",
                         i, ok, rsp_cmd, rsp_code, rsp_data, exp_cmd[i], exp_data[i]);
            end
            @(posedge c_clk); #1;
        end
        checks++;
        if (issued_op1.size() != 5) begin
            errors++;
            $display("FAIL b2b_issue_count: got %0d expected 5", issued_op1.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (issued_op1[i] !== exp_op1[i] || issued_cmd[i] !== exp_cmd[i]) begin
                    errors++;
                    $display("FAIL b2b_order%0d: got cmd=%h op1=%h expected %h %h",
                             i, issued_cmd[i], issued_op1[i], exp_cmd[i], exp_op1[i]);
                end
            end
        end
    endtask

    task automatic test_error_resp();
        logic [3:0]  exp_cmd  [3] = '{4'd2, 4'd9, 4'd1};
        logic [1:0]  exp_code [3] = '{2'd2, 2'd2, 2'd1};
        logic [31:0] exp_data [3] = '{32'd0, 32'd0, 32'd4};
        int cyc; bit ok;
        issued_cmd.delete(); issued_op1.delete();
        rsp_ready = 1'b1;
        push_txn(4'd2, 32'd1, 32'd2);
        push_txn(4'd9, 32'd1, 32'd1);
        push_txn(4'd1, 32'd2, 32'd2);
        for (int i = 0; i < 3; i++) begin
            wait_rsp(40, cyc, ok);
            checks++;
            if (!ok || rsp_cmd !== exp_cmd[i] || rsp_code !== exp_code[i] || rsp_data !== exp_data[i]) begin
                errors++;
                $display("FAIL err_rsp%0d: got valid=%b cmd=%h code=%h data=%h expected 1 %h %h %h",
                         i, ok, rsp_cmd, rsp_code, rsp_data, exp_cmd[i], exp_code[i], exp_data[i]);
            end
            @(posedge c_clk); #1;
        end
        checks++;
        if (issued_cmd.size() != 3 || issued_cmd[1] !== 4'd9) begin
            errors++;
            $display("FAIL invalid_cmd_issued: got count=%0d expected 3 with cmd 9 second", issued_cmd.size());
        end
    endtask

    task automatic test_hold_stable();
        int cyc; bit ok; bit bad; int n;
        rsp_ready = 1'b0;
        push_txn(4'd1, 32'd7, 32'd8);
        push_txn(4'd1, 32'd1, 32'd1);
        push_txn(4'd2, 32'd9, 32'd4);
        wait_rsp(40, cyc, ok);
        checks++;
        if (!ok || rsp_data !== 32'd15 || rsp_code !== 2'd1) begin
            errors++;
            $display("FAIL hold_first: got valid=%b code=%h data=%h expected 1 1 0000000f", ok, rsp_code, rsp_data);
        end
        n = issued_cmd.size();
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge c_clk); #1;
            if (rsp_valid !== 1'b1 || rsp_data !== 32'd15 || rsp_code !== 2'd1 || rsp_cmd !== 4'd1 ||
                rsp_timeout !== 1'b0 || req_cmd_out !== 4'd0) bad = 1'b1;
        end
        checks++;
        if (bad || issued_cmd.size() != n || dut.count_q !== 3'd2) begin
            errors++;
            $display("FAIL hold_stable: got changed=%b issues=%0d queued=%0d expected 0 %0d 2",
                     bad, issued_cmd.size(), dut.count_q, n);
        end
        rsp_ready = 1'b1;
        @(posedge c_clk); #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: got valid=%b expected 0", rsp_valid);
        end
        wait_rsp(40, cyc, ok);
        checks++;
        if (!ok || rsp_data !== 32'd2 || rsp_cmd !== 4'd1) begin
            errors++;
            $display("FAIL hold_second: got valid=%b data=%h cmd=%h expected 1 00000002 1", ok, rsp_data, rsp_cmd);
        end
        @(posedge c_clk); #1;
        wait_rsp(40, cyc, ok);
        checks++;
        if (!ok || rsp_data !== 32'd5 || rsp_cmd !== 4'd2) begin
            errors++;
            $display("FAIL hold_third: got valid=%b data=%h cmd=%h expected 1 00000005 2", ok, rsp_data, rsp_cmd);
        end
        @(posedge c_clk); #1;
    endtask

    // measures cycles from the cycle the command is on the bus until rsp_valid
    task automatic issue_and_measure(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                     output int cyc);
        int n = 0;
        push_txn(c, a, b);
        while (req_cmd_out !== c && n < 20) begin
            @(posedge c_clk); #1;
            n++;
        end
        cyc = 0;
        while (!rsp_valid && cyc < 100) begin
            @(posedge c_clk); #1;
            cyc++;
        end
    endtask

    task automatic test_timeout();
        int cyc;
        rsp_ready = 1'b1;
        model_silent = 1'b1;
        issue_and_measure(4'd5, 32'd1, 32'd3, cyc);
        checks++;
        if (cyc != 65 || rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL timeout_cycles: got %0d valid=%b expected 65 1", cyc, rsp_valid);
        end
        checks++;
        if (rsp_timeout !== 1'b1 || rsp_code !== 2'd0 || rsp_data !== 32'd0 || rsp_cmd !== 4'd5) begin
            errors++;
            $display("FAIL timeout_result: got tmo=%b code=%h data=%h cmd=%h expected 1 0 0 5",
                     rsp_timeout, rsp_code, rsp_data, rsp_cmd);
        end
        @(posedge c_clk); #1;
        model_silent = 1'b0;
    endtask

    task automatic test_timeout_race();
        int cyc;
        model_delay = 63;
        issue_and_measure(4'd1, 32'd3, 32'd4, cyc);
        checks++;
        if (cyc != 65 || rsp_timeout !== 1'b0 || rsp_code !== 2'd1 || rsp_data !== 32'd7) begin
            errors++;
            $display("FAIL timeout_race: got cycles=%0d tmo=%b code=%h data=%h expected 65 0 1 00000007",
                     cyc, rsp_timeout, rsp_code, rsp_data);
        end
        @(posedge c_clk); #1;
        model_delay = 2;
    endtask

    task automatic test_spurious();
        checks++;
        if (dut.spurious_q !== 1'b0) begin
            errors++;
            $display("FAIL spurious_clean: got %b expected 0", dut.spurious_q);
        end
        spur_resp = 2'd1;
        @(posedge c_clk); #1;
        spur_resp = 2'd0;
        @(posedge c_clk); #1;
        checks++;
        if (dut.spurious_q !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL spurious_idle: got spurious=%b valid=%b busy=%b expected 1 0 0",
                     dut.spurious_q, rsp_valid, busy);
        end
    endtask

    task automatic test_reset_mid();
        int cyc; bit ok; bit bad; int n;
        rsp_ready = 1'b0;
        push_txn(4'd1, 32'd1, 32'd1);
        wait_rsp(40, cyc, ok);
        model_silent = 1'b1;
        push_txn(4'd1, 32'd11, 32'd1);
        push_txn(4'd2, 32'd12, 32'd2);
        push_txn(4'd5, 32'd13, 32'd3);
        push_txn(4'd6, 32'd14, 32'd4);
        rsp_ready = 1'b1;
        n = 0;
        while (req_cmd_out === 4'd0 && n < 20) begin
            @(posedge c_clk); #1;
            n++;
        end
        checks++;
        if (req_cmd_out !== 4'd1 || req_data_out !== 32'd11 || dut.count_q !== 3'd3) begin
            errors++;
            $display("FAIL pre_reset_send: got cmd=%h data=%h queued=%0d expected 1 0000000b 3",
                     req_cmd_out, req_data_out, dut.count_q);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (req_cmd_out !== 4'd0 || req_data_out !== 32'd0 || rsp_valid !== 1'b0 || txn_ready !== 1'b1 ||
            dut.spurious_q !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got cmd=%h data=%h vld=%b ready=%b spurious=%b busy=%b expected 0 0 0 1 0 0",
                     req_cmd_out, req_data_out, rsp_valid, txn_ready, dut.spurious_q, busy);
        end
        @(negedge c_clk) reset = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge c_clk); #1;
            if (rsp_valid !== 1'b0 || req_cmd_out !== 4'd0 || busy !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL post_reset_quiet: discarded work resurfaced, got activity expected none");
        end
        model_silent = 1'b0;
    endtask

    initial begin
        test_reset_and_add();
        test_back_to_back();
        test_error_resp();
        test_hold_stable();
        test_timeout();
        test_timeout_race();
        test_spurious();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
